// File: rtl/icache_valid_lru.sv
// -----------------------------------------------------------------------------
// icache_valid_lru
//   Per-set valid and LRU state for a 2-way instruction cache (128 sets).
//   - Registered lookups for the fetch stage (read-before-write).
//   - Fill / hit / invalidate updates from the refill path, committed in IDLE.
//   - Full flush that sweeps one set per cycle (single-port SRAM friendly).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rd_en/rd_idx         lookup request and set index
//   rd_vld/rd_lru        registered lookup result (bit0 = way 0), held when idle
//   hit_en/idx/way       mark hit_way MRU in hit_idx
//   fill_en/idx/way      set valid for fill_way, make it MRU
//   inv_en/inv_idx       clear both ways of inv_idx, lru = 0
//   flush_req            flush-all pulse
//   busy                 flush in progress (FLUSH + DONE)
//   flush_done           one-cycle pulse in the last busy cycle
// -----------------------------------------------------------------------------

// decoder_7_128: one-hot set select, all zeros when disabled
module decoder_7_128 (
  input  logic         en,
  input  logic [6:0]   idx,
  output logic [127:0] sel
);

  // One-hot decode of the set index
  always_comb begin
    sel = {128{1'b0}};
    if (en) begin
      sel[idx] = 1'b1;
    end else begin
      sel = {128{1'b0}};
    end
  end

endmodule

module icache_valid_lru #(
  parameter int SETS  = 128,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_vld,
  output logic             rd_lru,
  input  logic             hit_en,
  input  logic [IDX_W-1:0] hit_idx,
  input  logic             hit_way,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic             fill_way,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [IDX_W-1:0] cnt_r, cnt_s;
  logic             idle_s;

  logic [SETS-1:0]  vld0_r, vld1_r, lru_r;
  logic [SETS-1:0]  vld0_s, vld1_s, lru_s;

  logic [SETS-1:0]  fill_sel_s, hit_sel_s, inv_sel_s, swp_sel_s;

  logic [1:0]       rd_vld_r;
  logic             rd_lru_r;
  logic             busy_r;
  logic             flush_done_r;

  assign idle_s = (state_r == ST_IDLE);

  // Updates are only accepted in IDLE; the sweep select is live only in FLUSH
  decoder_7_128 u_dec_fill (.en(fill_en & idle_s), .idx(fill_idx), .sel(fill_sel_s));
  decoder_7_128 u_dec_hit  (.en(hit_en  & idle_s), .idx(hit_idx),  .sel(hit_sel_s));
  decoder_7_128 u_dec_inv  (.en(inv_en  & idle_s), .idx(inv_idx),  .sel(inv_sel_s));
  decoder_7_128 u_dec_swp  (.en(state_r == ST_FLUSH), .idx(cnt_r), .sel(swp_sel_s));

  // Next-state and sweep counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = {IDX_W{1'b0}};
        if (flush_req) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        cnt_s = cnt_r + 7'd1;
        // Terminal on the last index itself, not on counter wrap
        if (cnt_r == 7'd127) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        cnt_s   = {IDX_W{1'b0}};
        state_s = ST_IDLE;
      end
      default: begin
        cnt_s   = {IDX_W{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {IDX_W{1'b0}};
      busy_r       <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      busy_r       <= (state_s != ST_IDLE);
      flush_done_r <= (state_s == ST_DONE);
    end
  end

  // Per-set update priority: sweep/inv clear, then fill, then hit
  always_comb begin
    vld0_s = vld0_r;
    vld1_s = vld1_r;
    lru_s  = lru_r;
    for (int s = 0; s < SETS; s++) begin
      if (swp_sel_s[s] | inv_sel_s[s]) begin
        vld0_s[s] = 1'b0;
        vld1_s[s] = 1'b0;
        lru_s[s]  = 1'b0;
      end else if (fill_sel_s[s]) begin
        if (fill_way == 1'b0) begin
          vld0_s[s] = 1'b1;
        end else begin
          vld1_s[s] = 1'b1;
        end
        lru_s[s] = ~fill_way;
      end else if (hit_sel_s[s]) begin
        lru_s[s] = ~hit_way;
      end else begin
        lru_s[s] = lru_r[s];
      end
    end
  end

  // Valid / LRU storage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_r <= {SETS{1'b0}};
      vld1_r <= {SETS{1'b0}};
      lru_r  <= {SETS{1'b0}};
    end else begin
      vld0_r <= vld0_s;
      vld1_r <= vld1_s;
      lru_r  <= lru_s;
    end
  end

  // Registered lookup: reads pre-update contents, zero while flushing
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_r <= 2'b00;
      rd_lru_r <= 1'b0;
    end else if (rd_en) begin
      if (busy_r) begin
        rd_vld_r <= 2'b00;
        rd_lru_r <= 1'b0;
      end else begin
        rd_vld_r <= {vld1_r[rd_idx], vld0_r[rd_idx]};
        rd_lru_r <= lru_r[rd_idx];
      end
    end else begin
      rd_vld_r <= rd_vld_r;
      rd_lru_r <= rd_lru_r;
    end
  end

  assign rd_vld     = rd_vld_r;
  assign rd_lru     = rd_lru_r;
  assign busy       = busy_r;
  assign flush_done = flush_done_r;

endmodule
